// File: rtl/host_if_master_if.sv
// rtl/host_if_master_if.sv - command/response handshake bundle for host_if_master
//
// Purpose: groups the host-side command request and completion response of
// host_if_master so both ends share one connection.
// Signals:
//   cmd_valid/cmd_ready : command handshake, transfer when both high
//   cmd_rd              : 1 = register read, 0 = register write
//   cmd_ep/addr/wdata   : endpoint, register address, write data (16 bits each)
//   rsp_valid           : one-cycle completion pulse
//   rsp_err/rsp_rdata   : timeout flag and read data, valid with rsp_valid
// Modports: master = host_if_master side, slave = command issuer side.
interface host_if_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_rd;
  logic [15:0] cmd_ep;
  logic [15:0] cmd_addr;
  logic [15:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_err;
  logic [15:0] rsp_rdata;

  modport master (
    input  cmd_valid, cmd_rd, cmd_ep, cmd_addr, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_err, rsp_rdata
  );

  modport slave (
    output cmd_valid, cmd_rd, cmd_ep, cmd_addr, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_err, rsp_rdata
  );
endinterface

// File: rtl/host_if_master.sv
// rtl/host_if_master.sv - phased register-access master for a state-coded peripheral bus
//
// Purpose: turns one host command into a sequence of SETEP / SETREG /
// SETRVAL / RDDATA phases on the peripheral bus, skipping SETEP/SETREG when
// the endpoint/address caches already hold the requested values.
// Ports:
//   if_clock  : interface clock, rising edge
//   resetb    : asynchronous active-low reset
//   io_host   : command/response handshake (host_if_master_if.master)
//   o_state   : phase code to peripheral (0 IDLE,1 SETEP,2 SETREG,3 SETRVAL,4 RDDATA)
//   o_ctl     : ctl[1] is the read/write strobe, ctl[0]/ctl[2] tied 0
//   o_oe      : high while the master drives io_data
//   i_rdy     : peripheral ready
//   io_data   : bidirectional 16-bit data bus
module host_if_master #(
  parameter int SETTLE  = 3,
  parameter int RD_LAT  = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                  if_clock,
  input  logic                  resetb,
  host_if_master_if.master      io_host,
  output logic [3:0]            o_state,
  output logic [2:0]            o_ctl,
  output logic                  o_oe,
  input  logic                  i_rdy,
  inout  wire  [15:0]           io_data
);

  typedef enum logic [2:0] {
    S_IDLE, S_PH_SETTLE, S_PH_WAIT, S_PH_STROBE, S_RD_LAT_WAIT, S_DONE
  } fsm_t;

  // Phase encoding is chosen so that state code = phase + 1.
  typedef enum logic [1:0] {P_EP, P_REG, P_VAL, P_RD} phase_t;

  fsm_t        r_fsm;
  phase_t      r_phase;
  logic        r_rd;
  logic [15:0] r_ep;
  logic [15:0] r_addr;
  logic [15:0] r_wdata;
  logic [15:0] r_cnt;
  logic [3:0]  r_state;
  logic        r_strobe;
  logic        r_oe;
  logic [15:0] r_dout;
  logic        r_cmd_ready;
  logic        r_rsp_valid;
  logic        r_rsp_err;
  logic [15:0] r_rsp_rdata;
  logic [15:0] r_ep_cache;
  logic        r_ep_vld;
  logic [15:0] r_addr_cache;
  logic        r_addr_vld;

  logic        w_accept;
  phase_t      w_enter_phase;
  logic [15:0] w_enter_data;

  // r_cmd_ready is only ever set while in IDLE.
  assign w_accept = io_host.cmd_valid & r_cmd_ready;

  // Phase to enter next: from IDLE it is the first uncached phase of the
  // incoming command, otherwise the successor of the phase just strobed.
  always_comb begin
    w_enter_phase = P_EP;
    if (r_fsm == S_IDLE) begin
      if (!(r_ep_vld && r_ep_cache == io_host.cmd_ep))
        w_enter_phase = P_EP;
      else if (!(r_addr_vld && r_addr_cache == io_host.cmd_addr))
        w_enter_phase = P_REG;
      else if (io_host.cmd_rd)
        w_enter_phase = P_RD;
      else
        w_enter_phase = P_VAL;
    end else if (r_phase == P_EP) begin
      w_enter_phase = P_REG;
    end else begin
      w_enter_phase = r_rd ? P_RD : P_VAL;
    end
  end

  // On accept the command fields are not latched yet, so take them directly.
  always_comb begin
    w_enter_data = 16'h0000;
    case (w_enter_phase)
      P_EP:    w_enter_data = (r_fsm == S_IDLE) ? io_host.cmd_ep    : r_ep;
      P_REG:   w_enter_data = (r_fsm == S_IDLE) ? io_host.cmd_addr  : r_addr;
      P_VAL:   w_enter_data = (r_fsm == S_IDLE) ? io_host.cmd_wdata : r_wdata;
      default: w_enter_data = 16'h0000;
    endcase
  end

  always_ff @(posedge if_clock or negedge resetb) begin
    if (!resetb) begin
      r_fsm        <= S_IDLE;
      r_phase      <= P_EP;
      r_rd         <= 1'b0;
      r_ep         <= 16'h0000;
      r_addr       <= 16'h0000;
      r_wdata      <= 16'h0000;
      r_cnt        <= 16'h0000;
      r_state      <= 4'd0;
      r_strobe     <= 1'b0;
      r_oe         <= 1'b0;
      r_dout       <= 16'h0000;
      r_cmd_ready  <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_err    <= 1'b0;
      r_rsp_rdata  <= 16'h0000;
      r_ep_cache   <= 16'h0000;
      r_ep_vld     <= 1'b0;
      r_addr_cache <= 16'h0000;
      r_addr_vld   <= 1'b0;
    end else begin
      r_strobe    <= 1'b0;
      r_rsp_valid <= 1'b0;
      case (r_fsm)
        S_IDLE: begin
          r_cmd_ready <= 1'b1;
          if (w_accept) begin
            r_cmd_ready <= 1'b0;
            r_rd        <= io_host.cmd_rd;
            r_ep        <= io_host.cmd_ep;
            r_addr      <= io_host.cmd_addr;
            r_wdata     <= io_host.cmd_wdata;
            r_fsm       <= S_PH_SETTLE;
            r_phase     <= w_enter_phase;
            r_state     <= {2'b00, w_enter_phase} + 4'd1;
            r_oe        <= (w_enter_phase != P_RD);
            r_dout      <= w_enter_data;
            r_cnt       <= 16'h0000;
          end
        end
        S_PH_SETTLE: begin
          if (r_cnt == 16'(SETTLE - 1)) begin
            r_cnt <= 16'h0000;
            // rdy already high at the end of settling: wait takes zero cycles.
            if (i_rdy) begin
              r_fsm    <= S_PH_STROBE;
              r_strobe <= 1'b1;
            end else begin
              r_fsm <= S_PH_WAIT;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_PH_WAIT: begin
          if (i_rdy) begin
            r_fsm    <= S_PH_STROBE;
            r_strobe <= 1'b1;
            r_cnt    <= 16'h0000;
          end else if (r_cnt == 16'(TIMEOUT - 1)) begin
            r_fsm       <= S_DONE;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_state     <= 4'd0;
            r_oe        <= 1'b0;
            r_ep_vld    <= 1'b0;
            r_addr_vld  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_PH_STROBE: begin
          r_cnt <= 16'h0000;
          case (r_phase)
            P_EP, P_REG: begin
              if (r_phase == P_EP) begin
                r_ep_cache <= r_ep;
                r_ep_vld   <= 1'b1;
              end else begin
                r_addr_cache <= r_addr;
                r_addr_vld   <= 1'b1;
              end
              r_fsm   <= S_PH_SETTLE;
              r_phase <= w_enter_phase;
              r_state <= {2'b00, w_enter_phase} + 4'd1;
              r_oe    <= (w_enter_phase != P_RD);
              r_dout  <= w_enter_data;
            end
            P_VAL: begin
              r_fsm       <= S_DONE;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b0;
              r_state     <= 4'd0;
              r_oe        <= 1'b0;
            end
            default: r_fsm <= S_RD_LAT_WAIT;
          endcase
        end
        S_RD_LAT_WAIT: begin
          if (r_cnt == 16'(RD_LAT - 1)) begin
            r_rsp_rdata <= io_data;
            r_fsm       <= S_DONE;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b0;
            r_state     <= 4'd0;
            r_oe        <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_DONE: begin
          r_fsm       <= S_IDLE;
          r_cmd_ready <= 1'b1;
        end
        default: r_fsm <= S_IDLE;
      endcase
    end
  end

  assign io_data           = r_oe ? r_dout : 16'hzzzz;
  assign o_state           = r_state;
  assign o_ctl             = {1'b0, r_strobe, 1'b0};
  assign o_oe              = r_oe;
  assign io_host.cmd_ready = r_cmd_ready;
  assign io_host.rsp_valid = r_rsp_valid;
  assign io_host.rsp_err   = r_rsp_err;
  assign io_host.rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_host_if_master.sv
// tb/tb_host_if_master.sv - directed self-checking bench for host_if_master
module tb_host_if_master;
  localparam int SETTLE  = 3;
  localparam int RD_LAT  = 2;
  localparam int TIMEOUT = 255;

  logic        clk = 1'b0;
  logic        resetb = 1'b0;
  logic        rdy = 1'b0;
  logic        drv = 1'b0;
  logic [15:0] drv_val = 16'h0000;
  wire  [15:0] bus;
  logic [3:0]  st;
  logic [2:0]  ctl;
  logic        oe;

  host_if_master_if host();

  host_if_master #(.SETTLE(SETTLE), .RD_LAT(RD_LAT), .TIMEOUT(TIMEOUT)) dut (
    .if_clock (clk),
    .resetb   (resetb),
    .io_host  (host),
    .o_state  (st),
    .o_ctl    (ctl),
    .o_oe     (oe),
    .i_rdy    (rdy),
    .io_data  (bus)
  );

  // Peripheral drives read data only while RDDATA is presented.
  assign bus = (drv && st == 4'd4) ? drv_val : 16'hzzzz;

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  int          n_strobe = 0;
  int          n_rsp = 0;
  int          n_oe_rd = 0;
  int          n_ctl_bad = 0;
  int          cnt_state [16];
  logic [19:0] slog [$];

  always @(negedge clk) begin
    cnt_state[st] = cnt_state[st] + 1;
    if (ctl[1]) begin
      n_strobe = n_strobe + 1;
      slog.push_back({st, bus});
    end
    if (st == 4'd4 && oe) n_oe_rd = n_oe_rd + 1;
    if (ctl[0] || ctl[2]) n_ctl_bad = n_ctl_bad + 1;
    if (host.rsp_valid) n_rsp = n_rsp + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic issue_cmd(input logic rd, input logic [15:0] ep, input logic [15:0] addr,
                           input logic [15:0] wdata);
    int n = 0;
    @(negedge clk);
    while (!host.cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_ready_wait", {31'd0, host.cmd_ready}, 32'd1);
    host.cmd_valid = 1'b1;
    host.cmd_rd    = rd;
    host.cmd_ep    = ep;
    host.cmd_addr  = addr;
    host.cmd_wdata = wdata;
    @(posedge clk);
    #1;
    host.cmd_valid = 1'b0;
    host.cmd_rd    = ~rd;
    host.cmd_ep    = 16'hDEAD;
    host.cmd_addr  = 16'hDEAD;
    host.cmd_wdata = 16'hDEAD;
  endtask

  task automatic wait_rsp(input int budget, output logic got, output logic err,
                          output logic [15:0] rdata);
    got = 1'b0;
    err = 1'b0;
    rdata = 16'h0000;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (host.rsp_valid) begin
        got = 1'b1;
        err = host.rsp_err;
        rdata = host.rsp_rdata;
      end
    end
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    int s0, q0, r0, c1, c2, c3, c4;
    logic got, err;
    logic [15:0] rdata;
    logic found;

    host.cmd_valid = 1'b0;
    host.cmd_rd    = 1'b0;
    host.cmd_ep    = 16'h0000;
    host.cmd_addr  = 16'h0000;
    host.cmd_wdata = 16'h0000;

    // Reset state
    #12;
    chk("rst_state", {28'd0, st}, 32'd0);
    chk("rst_ctl", {29'd0, ctl}, 32'd0);
    chk("rst_oe", {31'd0, oe}, 32'd0);
    chk("rst_cmd_ready", {31'd0, host.cmd_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, host.rsp_valid}, 32'd0);
    chk("rst_rsp_err", {31'd0, host.rsp_err}, 32'd0);
    chk("rst_rsp_rdata", {16'd0, host.rsp_rdata}, 32'd0);
    @(negedge clk);
    resetb = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_cmd_ready", {31'd0, host.cmd_ready}, 32'd1);
    rdy = 1'b1;

    // Cold-cache write: SETEP, SETREG, SETRVAL each held SETTLE+1 cycles
    s0 = n_strobe; q0 = slog.size(); r0 = n_rsp;
    c1 = cnt_state[1]; c2 = cnt_state[2]; c3 = cnt_state[3];
    issue_cmd(1'b0, 16'h0002, 16'h0010, 16'hBEEF);
    wait_rsp(100, got, err, rdata);
    chk("w1_rsp", {31'd0, got}, 32'd1);
    chk("w1_err", {31'd0, err}, 32'd0);
    chk("w1_nstrobe", n_strobe - s0, 32'd3);
    chk("w1_stb_ep", {12'd0, slog[q0]}, {12'd0, 4'd1, 16'h0002});
    chk("w1_stb_reg", {12'd0, slog[q0+1]}, {12'd0, 4'd2, 16'h0010});
    chk("w1_stb_val", {12'd0, slog[q0+2]}, {12'd0, 4'd3, 16'hBEEF});
    chk("w1_hold1", cnt_state[1] - c1, 32'd4);
    chk("w1_hold2", cnt_state[2] - c2, 32'd4);
    chk("w1_hold3", cnt_state[3] - c3, 32'd4);
    chk("w1_nrsp", n_rsp - r0, 32'd1);

    // Cached write: only SETRVAL
    s0 = n_strobe; q0 = slog.size();
    c1 = cnt_state[1]; c2 = cnt_state[2]; c3 = cnt_state[3];
    issue_cmd(1'b0, 16'h0002, 16'h0010, 16'h1234);
    wait_rsp(100, got, err, rdata);
    chk("w2_rsp", {31'd0, got}, 32'd1);
    chk("w2_nstrobe", n_strobe - s0, 32'd1);
    chk("w2_stb_val", {12'd0, slog[q0]}, {12'd0, 4'd3, 16'h1234});
    chk("w2_skip1", cnt_state[1] - c1, 32'd0);
    chk("w2_skip2", cnt_state[2] - c2, 32'd0);
    chk("w2_hold3", cnt_state[3] - c3, 32'd4);

    // Cached read: RDDATA only, master never drives
    drv = 1'b1; drv_val = 16'hA5A5;
    s0 = n_strobe; q0 = slog.size(); r0 = n_oe_rd; c4 = cnt_state[4];
    issue_cmd(1'b1, 16'h0002, 16'h0010, 16'h0000);
    wait_rsp(100, got, err, rdata);
    chk("r1_rsp", {31'd0, got}, 32'd1);
    chk("r1_err", {31'd0, err}, 32'd0);
    chk("r1_rdata", {16'd0, rdata}, 32'h0000A5A5);
    chk("r1_oe_in_rd", n_oe_rd - r0, 32'd0);
    chk("r1_nstrobe", n_strobe - s0, 32'd1);
    chk("r1_stb_rd", {12'd0, slog[q0]}, {12'd0, 4'd4, 16'hA5A5});
    chk("r1_hold4", cnt_state[4] - c4, 32'd6);
    drv = 1'b0;

    // Timeout in VAL phase
    rdy = 1'b0;
    s0 = n_strobe; c3 = cnt_state[3];
    issue_cmd(1'b0, 16'h0002, 16'h0010, 16'h5555);
    wait_rsp(400, got, err, rdata);
    chk("to_rsp", {31'd0, got}, 32'd1);
    chk("to_err", {31'd0, err}, 32'd1);
    chk("to_nstrobe", n_strobe - s0, 32'd0);
    chk("to_hold3", cnt_state[3] - c3, 32'd258);
    chk("to_rdata_kept", {16'd0, rdata}, 32'h0000A5A5);
    rdy = 1'b1;
    s0 = n_strobe; q0 = slog.size();
    issue_cmd(1'b0, 16'h0002, 16'h0010, 16'h0001);
    wait_rsp(100, got, err, rdata);
    chk("after_to_err", {31'd0, err}, 32'd0);
    chk("after_to_nstrobe", n_strobe - s0, 32'd3);
    chk("after_to_stb_ep", {12'd0, slog[q0]}, {12'd0, 4'd1, 16'h0002});

    // Reset during the REG strobe
    issue_cmd(1'b0, 16'h0002, 16'h0020, 16'h4444);
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (st == 4'd2 && ctl[1]) found = 1'b1;
    end
    chk("rst_mid_found", {31'd0, found}, 32'd1);
    r0 = n_rsp;
    resetb = 1'b0;
    #1;
    chk("rst_mid_state", {28'd0, st}, 32'd0);
    chk("rst_mid_ctl", {29'd0, ctl}, 32'd0);
    chk("rst_mid_oe", {31'd0, oe}, 32'd0);
    chk("rst_mid_cmd_ready", {31'd0, host.cmd_ready}, 32'd0);
    repeat (3) @(negedge clk);
    #1;
    chk("rst_mid_nrsp", n_rsp - r0, 32'd0);
    resetb = 1'b1;
    s0 = n_strobe; q0 = slog.size();
    issue_cmd(1'b0, 16'h0003, 16'h0030, 16'h7777);
    wait_rsp(100, got, err, rdata);
    chk("post_rst_rsp", {31'd0, got}, 32'd1);
    chk("post_rst_err", {31'd0, err}, 32'd0);
    chk("post_rst_nstrobe", n_strobe - s0, 32'd3);
    chk("post_rst_stb_val", {12'd0, slog[q0+2]}, {12'd0, 4'd3, 16'h7777});

    // cmd_valid while busy is ignored
    s0 = n_strobe; q0 = slog.size(); r0 = n_rsp;
    issue_cmd(1'b0, 16'h0003, 16'h0030, 16'h9999);
    @(negedge clk);
    host.cmd_valid = 1'b1;
    host.cmd_wdata = 16'hBAD0;
    repeat (2) @(negedge clk);
    host.cmd_valid = 1'b0;
    wait_rsp(100, got, err, rdata);
    repeat (20) @(negedge clk);
    #1;
    chk("busy_nrsp", n_rsp - r0, 32'd1);
    chk("busy_nstrobe", n_strobe - s0, 32'd1);
    chk("busy_stb_val", {12'd0, slog[q0]}, {12'd0, 4'd3, 16'h9999});
    chk("ctl_unused_bits", n_ctl_bad, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
